// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - prescale shadowing, FWFT byte FIFO, error counters and idle timeout for uart_rx
module uart_rx_ctrl #(
    parameter int          FIFO_DEPTH   = 4,
    parameter int          CNT_W        = 8,
    parameter int          TIMEOUT_CYC  = 480,
    parameter logic [15:0] PRESCALE_RST = 16'd6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [15:0]                   cfg_prescale,
    input  logic                          cfg_wr,
    output logic [15:0]                   prescale,
    output logic                          cfg_pending,
    input  logic                          rx_busy,
    input  logic                          rx_overrun_error,
    input  logic                          rx_frame_error,
    input  logic [7:0]                    s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [7:0]                    m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              ovr_count,
    output logic [CNT_W-1:0]              frm_count,
    input  logic                          clr_counters,
    output logic                          idle_timeout
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic {CFG_IDLE, CFG_PEND} cfg_state_t;

    cfg_state_t      r_cfg_state;
    logic [15:0]     r_shadow;
    logic [15:0]     r_prescale;
    logic            r_cfg_pending;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;

    logic            r_ovr_q;
    logic            r_frm_q;
    logic [CNT_W-1:0] r_ovr_cnt;
    logic [CNT_W-1:0] r_frm_cnt;

    logic            r_armed;
    logic [TW-1:0]   r_idle_cnt;
    logic            r_idle_timeout;

    logic            w_wr;
    logic            w_rd;
    logic            w_ovr_rise;
    logic            w_frm_rise;

    assign prescale      = r_prescale;
    assign cfg_pending   = r_cfg_pending;
    assign s_axis_tready = (r_level != LVL_FULL);
    assign m_axis_tvalid = (r_level != '0);
    assign m_axis_tdata  = m_axis_tvalid ? r_mem[r_rd_ptr] : 8'h00;
    assign fifo_level    = r_level;
    assign ovr_count     = r_ovr_cnt;
    assign frm_count     = r_frm_cnt;
    assign idle_timeout  = r_idle_timeout;

    assign w_wr       = s_axis_tvalid & s_axis_tready;
    assign w_rd       = m_axis_tvalid & m_axis_tready;
    assign w_ovr_rise = rx_overrun_error & ~r_ovr_q;
    assign w_frm_rise = rx_frame_error & ~r_frm_q;

    // A write while idle applies at once; otherwise it waits in the shadow until rx_busy drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cfg_state   <= CFG_IDLE;
            r_shadow      <= 16'h0000;
            r_prescale    <= PRESCALE_RST;
            r_cfg_pending <= 1'b0;
        end else begin
            case (r_cfg_state)
                CFG_IDLE: begin
                    if (cfg_wr) begin
                        r_shadow <= cfg_prescale;
                        if (!rx_busy) begin
                            r_prescale <= cfg_prescale;
                        end else begin
                            r_cfg_state   <= CFG_PEND;
                            r_cfg_pending <= 1'b1;
                        end
                    end
                end
                CFG_PEND: begin
                    if (!rx_busy) begin
                        r_prescale <= r_shadow;
                    end
                    if (cfg_wr) begin
                        r_shadow <= cfg_prescale;
                    end else if (!rx_busy) begin
                        r_cfg_state   <= CFG_IDLE;
                        r_cfg_pending <= 1'b0;
                    end
                end
                default: begin
                    r_cfg_state   <= CFG_IDLE;
                    r_cfg_pending <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= s_axis_tdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovr_q   <= 1'b0;
            r_frm_q   <= 1'b0;
            r_ovr_cnt <= '0;
            r_frm_cnt <= '0;
        end else begin
            r_ovr_q <= rx_overrun_error;
            r_frm_q <= rx_frame_error;
            if (clr_counters) begin
                r_ovr_cnt <= '0;
                r_frm_cnt <= '0;
            end else begin
                if (w_ovr_rise && (r_ovr_cnt != '1)) begin
                    r_ovr_cnt <= r_ovr_cnt + CNT_W'(1);
                end
                if (w_frm_rise && (r_frm_cnt != '1)) begin
                    r_frm_cnt <= r_frm_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Any busy cycle restarts the idle count; the timer disarms after its single pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_armed        <= 1'b0;
            r_idle_cnt     <= '0;
            r_idle_timeout <= 1'b0;
        end else begin
            r_idle_timeout <= 1'b0;
            if (w_wr) begin
                r_armed    <= 1'b1;
                r_idle_cnt <= '0;
            end else if (r_armed) begin
                if (rx_busy) begin
                    r_idle_cnt <= '0;
                end else if (r_idle_cnt == IDLE_LAST) begin
                    r_idle_timeout <= 1'b1;
                    r_armed        <= 1'b0;
                    r_idle_cnt     <= '0;
                end else begin
                    r_idle_cnt <= r_idle_cnt + TW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard bench for uart_rx_ctrl with randomized traffic
module tb_uart_rx_ctrl;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 480;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cfg_prescale = '0;
    logic        cfg_wr = 1'b0;
    logic [15:0] prescale;
    logic        cfg_pending;
    logic        rx_busy = 1'b0;
    logic        rx_overrun_error = 1'b0;
    logic        rx_frame_error = 1'b0;
    logic [7:0]  s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic [2:0]  fifo_level;
    logic [7:0]  ovr_count;
    logic [7:0]  frm_count;
    logic        clr_counters = 1'b0;
    logic        idle_timeout;

    int vectors = 0;
    int miscompares = 0;
    bit mon_en = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx_ctrl #(
        .FIFO_DEPTH(DEPTH), .CNT_W(8), .TIMEOUT_CYC(TIMEOUT), .PRESCALE_RST(16'd6)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_prescale(cfg_prescale), .cfg_wr(cfg_wr),
        .prescale(prescale), .cfg_pending(cfg_pending),
        .rx_busy(rx_busy), .rx_overrun_error(rx_overrun_error), .rx_frame_error(rx_frame_error),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .fifo_level(fifo_level), .ovr_count(ovr_count), .frm_count(frm_count),
        .clr_counters(clr_counters), .idle_timeout(idle_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: FIFO model is an ordered queue of accepted bytes bounded by DEPTH.
    always @(negedge clk) begin
        if (mon_en) begin
            int sz;
            bit rd, wr;
            sz = exp_q.size();
            chk("fifo_level", 32'(fifo_level), sz);
            chk("s_tready", 32'(s_axis_tready), 32'(sz != DEPTH));
            chk("m_tvalid", 32'(m_axis_tvalid), 32'(sz != 0));
            if (sz != 0) chk("m_tdata", 32'(m_axis_tdata), 32'(exp_q[0]));
            rd = (sz != 0) && m_axis_tready;
            wr = s_axis_tvalid && (sz < DEPTH);
            if (rd) void'(exp_q.pop_front());
            if (wr) exp_q.push_back(s_axis_tdata);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_prescale"}, 32'(prescale), 32'd6);
        chk({tag, "_pending"}, 32'(cfg_pending), 0);
        chk({tag, "_level"}, 32'(fifo_level), 0);
        chk({tag, "_tvalid"}, 32'(m_axis_tvalid), 0);
        chk({tag, "_tdata"}, 32'(m_axis_tdata), 0);
        chk({tag, "_tready"}, 32'(s_axis_tready), 1);
        chk({tag, "_ovr"}, 32'(ovr_count), 0);
        chk({tag, "_frm"}, 32'(frm_count), 0);
        chk({tag, "_timeout"}, 32'(idle_timeout), 0);
    endtask

    task automatic timeout_run(input int busy_at, input int expect_at);
        int pulses;
        int at;
        pulses = 0;
        at = -1;
        s_axis_tdata  = 8'($urandom);
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b1;
        tick;
        s_axis_tvalid = 1'b0;
        for (int k = 1; k <= 1000; k++) begin
            rx_busy = (k == busy_at);
            tick;
            if (idle_timeout) begin
                pulses++;
                at = k;
            end
        end
        rx_busy = 1'b0;
        chk("timeout_pulses", pulses, 1);
        chk("timeout_edge", at, expect_at);
    endtask

    initial begin
        logic [15:0] cur_ps;
        logic [15:0] va, vb;
        logic [7:0]  burst [5];
        int pend_seen;
        int pulses;
        int n;

        burst[0] = 8'hA5; burst[1] = 8'h5A; burst[2] = 8'h3C; burst[3] = 8'hC3; burst[4] = 8'h0F;

        repeat (3) tick;
        check_reset_outputs("reset");
        rst = 1'b0;
        pulses = 0;
        repeat (TIMEOUT + 20) begin
            tick;
            if (idle_timeout) pulses++;
        end
        chk("no_timeout_before_byte", pulses, 0);

        // Immediate apply while the receiver is idle; pending must never assert.
        pend_seen = 0;
        for (int i = 0; i < 5; i++) begin
            va = (i == 0) ? 16'd12 : 16'($urandom);
            cfg_prescale = va;
            cfg_wr = 1'b1;
            tick;
            cfg_wr = 1'b0;
            if (cfg_pending) pend_seen++;
            chk("cfg_immediate", 32'(prescale), 32'(va));
            cur_ps = va;
        end
        chk("cfg_pending_never", pend_seen, 0);

        // Deferred apply, last write wins.
        va = (cur_ps == 16'd20) ? 16'd21 : 16'd20;
        vb = 16'd24;
        rx_busy = 1'b1;
        cfg_prescale = va; cfg_wr = 1'b1; tick;
        chk("cfg_pend_set", 32'(cfg_pending), 1);
        cfg_prescale = vb; tick;
        cfg_wr = 1'b0;
        repeat ($urandom_range(1, 10)) tick;
        chk("cfg_hold_prescale", 32'(prescale), 32'(cur_ps));
        chk("cfg_hold_pending", 32'(cfg_pending), 1);
        rx_busy = 1'b0;
        tick;
        chk("cfg_apply_prescale", 32'(prescale), 32'(vb));
        chk("cfg_apply_pending", 32'(cfg_pending), 0);
        cur_ps = vb;

        // Write landing on the apply cycle: older value applies, newer stays pending.
        va = 16'($urandom); vb = 16'($urandom);
        rx_busy = 1'b1;
        cfg_prescale = va; cfg_wr = 1'b1; tick;
        rx_busy = 1'b0;
        cfg_prescale = vb; tick;
        cfg_wr = 1'b0;
        chk("cfg_collide_prescale", 32'(prescale), 32'(va));
        chk("cfg_collide_pending", 32'(cfg_pending), 1);
        tick;
        chk("cfg_collide_final", 32'(prescale), 32'(vb));
        chk("cfg_collide_clear", 32'(cfg_pending), 0);

        // Burst into a stalled consumer, overrun, then drain in order.
        mon_en = 1'b1;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_axis_tdata = burst[i]; s_axis_tvalid = 1'b1; tick;
        end
        s_axis_tdata = burst[4];
        repeat (3) tick;
        rx_overrun_error = 1'b1; repeat (2) tick;
        rx_overrun_error = 1'b0; tick;
        chk("ovr_count_one", 32'(ovr_count), 1);
        m_axis_tready = 1'b1;
        repeat (2) tick;
        s_axis_tvalid = 1'b0;

        // Randomized traffic with varying consumer pressure.
        for (int blk = 0; blk < 6; blk++) begin
            int p_rdy;
            p_rdy = $urandom_range(0, 4);
            for (int c = 0; c < 50; c++) begin
                s_axis_tvalid = ($urandom_range(0, 3) != 0);
                s_axis_tdata  = 8'($urandom);
                m_axis_tready = ($urandom_range(0, 3) < p_rdy);
                tick;
            end
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        repeat (DEPTH + 4) tick;
        chk("drain_level", 32'(fifo_level), 0);
        mon_en = 1'b0;

        // Error counters: saturation, clear priority, level counts once.
        for (int i = 0; i < 300; i++) begin
            rx_frame_error = 1'b1; tick;
            rx_frame_error = 1'b0; tick;
        end
        chk("frm_saturate", 32'(frm_count), 255);
        chk("ovr_unchanged", 32'(ovr_count), 1);
        rx_frame_error = 1'b1; clr_counters = 1'b1; tick;
        clr_counters = 1'b0;
        repeat (3) tick;
        chk("clr_frm", 32'(frm_count), 0);
        chk("clr_ovr", 32'(ovr_count), 0);
        rx_frame_error = 1'b0; tick;
        n = $urandom_range(1, 40);
        for (int i = 0; i < n; i++) begin
            rx_frame_error = 1'b1; repeat ($urandom_range(1, 4)) tick;
            rx_frame_error = 1'b0; repeat ($urandom_range(1, 3)) tick;
        end
        chk("frm_random_pulses", 32'(frm_count), n);

        // Idle timeout: plain idle, then a busy cycle restarting the count.
        timeout_run(0, TIMEOUT);
        n = $urandom_range(1, 400);
        timeout_run(n, n + TIMEOUT);

        // Asynchronous reset with bytes buffered and a config pending.
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata = 8'($urandom); tick;
        s_axis_tdata = 8'($urandom); tick;
        s_axis_tvalid = 1'b0;
        rx_busy = 1'b1;
        cfg_prescale = 16'($urandom) | 16'h0100; cfg_wr = 1'b1; tick;
        cfg_wr = 1'b0;
        rx_frame_error = 1'b1; tick;
        rx_frame_error = 1'b0; tick;
        chk("pre_rst_level", 32'(fifo_level), 2);
        chk("pre_rst_pending", 32'(cfg_pending), 1);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        tick;
        rst = 1'b0;
        rx_busy = 1'b0;
        repeat (3) tick;
        chk("post_rst_prescale", 32'(prescale), 32'd6);
        chk("post_rst_pending", 32'(cfg_pending), 0);
        chk("post_rst_level", 32'(fifo_level), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
